// File: rtl/rob_inorder_retire.sv
// Reorder buffer: allocates tags in order, accepts completions in any order and
// retires payloads strictly in allocation order over a valid/ready output.
module rob_inorder_retire #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 8,
  localparam int unsigned TAG_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_req_i,
  output logic              alloc_gnt_o,
  output logic [TAG_W-1:0]  alloc_tag_o,
  input  logic              cpl_valid_i,
  input  logic [TAG_W-1:0]  cpl_tag_i,
  input  logic [DATA_W-1:0] cpl_data_i,
  output logic              cpl_err_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [TAG_W-1:0]  out_tag_o,
  input  logic              flush_i,
  output logic [TAG_W:0]    count_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam logic [TAG_W:0] DepthCnt = (TAG_W+1)'(DEPTH);
  localparam logic [TAG_W:0] PtrOne   = (TAG_W+1)'(1);

  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  alloc_q, alloc_d;
  logic [DEPTH-1:0]  done_q, done_d;
  logic [TAG_W:0]    head_q, head_d;
  logic [TAG_W:0]    tail_q, tail_d;
  logic              cpl_err_q, cpl_err_d;

  logic [TAG_W-1:0]  head_idx, tail_idx;
  logic              cpl_legal;
  logic              retire;

  assign head_idx = head_q[TAG_W-1:0];
  assign tail_idx = tail_q[TAG_W-1:0];

  // Occupancy comes from registered pointers only; the wrap bit disambiguates full/empty.
  assign count_o = tail_q - head_q;
  assign full_o  = (count_o == DepthCnt);
  assign empty_o = (count_o == '0);

  assign alloc_gnt_o = alloc_req_i && !full_o && !flush_i;
  assign alloc_tag_o = tail_idx;

  assign out_valid_o = alloc_q[head_idx] && done_q[head_idx];
  assign out_data_o  = data_q[head_idx];
  assign out_tag_o   = head_idx;
  assign retire      = out_valid_o && out_ready_i;

  // Judged against pre-edge state: a same-cycle allocation of the same index is not yet visible.
  assign cpl_legal = cpl_valid_i && alloc_q[cpl_tag_i] && !done_q[cpl_tag_i];

  assign cpl_err_o = cpl_err_q;

  always_comb begin
    alloc_d   = alloc_q;
    done_d    = done_q;
    head_d    = head_q;
    tail_d    = tail_q;
    cpl_err_d = 1'b0;
    if (flush_i) begin
      alloc_d = '0;
      done_d  = '0;
      head_d  = '0;
      tail_d  = '0;
    end else begin
      cpl_err_d = cpl_valid_i && !cpl_legal;
      if (retire) begin
        alloc_d[head_idx] = 1'b0;
        done_d[head_idx]  = 1'b0;
        head_d            = head_q + PtrOne;
      end
      if (cpl_legal) begin
        done_d[cpl_tag_i] = 1'b1;
      end
      if (alloc_gnt_o) begin
        alloc_d[tail_idx] = 1'b1;
        done_d[tail_idx]  = 1'b0;
        tail_d            = tail_q + PtrOne;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alloc_q   <= '0;
      done_q    <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      cpl_err_q <= 1'b0;
    end else begin
      alloc_q   <= alloc_d;
      done_q    <= done_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      cpl_err_q <= cpl_err_d;
    end
  end

  // Payload storage needs no reset; it is only observed once its done bit is set.
  always_ff @(posedge clk) begin
    if (cpl_legal && !flush_i) begin
      data_q[cpl_tag_i] <= cpl_data_i;
    end
  end

endmodule
